env_write_sink: RTL

- Receiving end of the environment write stream issued by the simulation state controller as it sweeps the 160x120 grid.
- Each write carries a cell coordinate, a pheromone signal value and a sugar flag.
- The block buffers writes in a small FIFO, commits them to an on-chip grid RAM at one per cycle, and serves a registered render read port for the colour mapper.
- On reset and on request, it clears the whole grid before it accepts any writes.

---
 rtl/env_write_sink.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/env_write_sink.sv
// Environment write sink: buffers grid writes, commits one per cycle to the grid RAM, serves render reads.
// Optional tail coalescing of repeated cell writes is enabled by defining ENV_WRITE_SINK_COALESCE_EN.
module env_write_sink #(
    parameter int unsigned X_BITS      = 8,
    parameter int unsigned Y_BITS      = 7,
    parameter int unsigned X_MAX       = 160,
    parameter int unsigned Y_MAX       = 120,
    parameter int unsigned SIGNAL_BITS = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [X_BITS-1:0]      wr_x,
    input  logic [Y_BITS-1:0]      wr_y,
    input  logic [SIGNAL_BITS-1:0] wr_signal,
    input  logic                   wr_sugar,
    input  logic                   clear_req,
    output logic                   busy,
    output logic [7:0]             drop_cnt,
    input  logic [X_BITS-1:0]      render_x,
    input  logic [Y_BITS-1:0]      render_y,
    output logic [SIGNAL_BITS-1:0] render_signal,
    output logic                   render_sugar
);

    localparam int unsigned CELLS     = X_MAX * Y_MAX;
    localparam int unsigned ADDR_BITS = $clog2(CELLS);
    localparam int unsigned FULL_BITS = X_BITS + Y_BITS + 1;
    localparam int unsigned XC_BITS   = X_BITS + 1;
    localparam int unsigned YC_BITS   = Y_BITS + 1;
    localparam int unsigned DATA_BITS = SIGNAL_BITS + 1;
    localparam int unsigned PTR_BITS  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITS  = PTR_BITS + 1;
    localparam int unsigned DROP_BITS = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [X_BITS-1:0]      x;
        logic [Y_BITS-1:0]      y;
        logic [SIGNAL_BITS-1:0] sig;
        logic                   sugar;
    } entry_t;

    function automatic logic in_range(input logic [X_BITS-1:0] x, input logic [Y_BITS-1:0] y);
        return ({1'b0, x} < XC_BITS'(X_MAX)) && ({1'b0, y} < YC_BITS'(Y_MAX));
    endfunction

    // Full-width y*X_MAX + x; only narrowed once the coordinate is known to be in range.
    function automatic logic [ADDR_BITS-1:0] cell_addr(input logic [X_BITS-1:0] x,
                                                       input logic [Y_BITS-1:0] y);
        logic [FULL_BITS-1:0] full;
        full = FULL_BITS'(y) * FULL_BITS'(X_MAX) + FULL_BITS'(x);
        return ADDR_BITS'(full);
    endfunction

    state_t                state, state_nxt;
    logic [ADDR_BITS-1:0]  clr_addr, clr_addr_nxt;
    entry_t                fifo_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   rd_ptr, wr_ptr;
    logic [CNT_BITS-1:0]   count, count_nxt;
    entry_t                head, wr_entry;
    logic                  push, pop, alloc, coalesce, flush, drop_inc;
    logic                  ram_we;
    logic [ADDR_BITS-1:0]  ram_addr;
    logic [DATA_BITS-1:0]  ram_wdata;
    logic [DATA_BITS-1:0]  ram [CELLS];

    assign wr_entry = '{x: wr_x, y: wr_y, sig: wr_signal, sugar: wr_sugar};

    // Next-state, FIFO control and RAM port selection.
    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        flush        = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        coalesce     = 1'b0;
        drop_inc     = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = clr_addr;
        ram_wdata    = '0;
        head         = fifo_mem[rd_ptr];
        case (state)
            ST_CLEAR: begin
                ram_we       = 1'b1;
                clr_addr_nxt = clr_addr + ADDR_BITS'(1);
                if (clr_addr == ADDR_BITS'(CELLS - 1)) begin
                    state_nxt    = ST_RUN;
                    clr_addr_nxt = '0;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    flush        = 1'b1;
                    state_nxt    = ST_CLEAR;
                    clr_addr_nxt = '0;
                end else begin
                    push = wr_valid && wr_ready;
                    pop  = (count != '0);
                    if (pop) begin
                        if (in_range(head.x, head.y)) begin
                            ram_we    = 1'b1;
                            ram_addr  = cell_addr(head.x, head.y);
                            ram_wdata = {head.sugar, head.sig};
                        end else begin
                            drop_inc = 1'b1;
                        end
                    end
`ifdef ENV_WRITE_SINK_COALESCE_EN
                    // Tail survives this cycle only when something else is ahead of it.
                    coalesce = push && (count > CNT_BITS'(1))
                             && (fifo_mem[wr_ptr - PTR_BITS'(1)].x == wr_x)
                             && (fifo_mem[wr_ptr - PTR_BITS'(1)].y == wr_y);
`endif
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
        alloc     = push && !coalesce;
        count_nxt = flush ? '0 : (count + CNT_BITS'(alloc) - CNT_BITS'(pop));
    end

    // State, pointers, counters and status outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
            count    <= count_nxt;
            busy     <= (state_nxt == ST_CLEAR);
            wr_ready <= (state_nxt == ST_RUN) && (count_nxt != CNT_BITS'(FIFO_DEPTH));
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)   rd_ptr <= rd_ptr + PTR_BITS'(1);
                if (alloc) wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (drop_inc && (drop_cnt != {DROP_BITS{1'b1}})) begin
                drop_cnt <= drop_cnt + DROP_BITS'(1);
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge Clk) begin
        if (alloc) begin
            fifo_mem[wr_ptr] <= wr_entry;
        end
`ifdef ENV_WRITE_SINK_COALESCE_EN
        else if (coalesce) begin
            fifo_mem[wr_ptr - PTR_BITS'(1)].sig   <= wr_signal;
            fifo_mem[wr_ptr - PTR_BITS'(1)].sugar <= wr_sugar;
        end
`endif
    end

    // Grid RAM write port.
    always_ff @(posedge Clk) begin
        if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
    end

    // Render read port; a same-cycle commit to the same cell is seen on the following read.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            render_signal <= '0;
            render_sugar  <= 1'b0;
        end else if (in_range(render_x, render_y)) begin
            {render_sugar, render_signal} <= ram[cell_addr(render_x, render_y)];
        end else begin
            render_signal <= '0;
            render_sugar  <= 1'b0;
        end
    end

endmodule
